// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one mem_bus between two requesters.
// All outputs are registered; the next value of every register is formed in one comb process.
module mem_bus_arbiter #(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_is_write,
    input  logic [2:0]        p0_num_bytes,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_done,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_is_write,
    input  logic [2:0]        p1_num_bytes,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_done,
    output logic [31:0]       p1_rdata,
    output logic              m_start,
    output logic              m_is_write,
    output logic [2:0]        m_num_bytes,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_done,
    input  logic [31:0]       m_rdata,
    output logic              owner,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, RELEASE} state_t;
    state_t state, state_n;
    logic              m_start_n, m_is_write_n, p0_done_n, p1_done_n, owner_n;
    logic [2:0]        m_num_bytes_n, win_bytes;
    logic [ADDR_W-1:0] m_addr_n;
    logic [31:0]       m_wdata_n, p0_rdata_n, p1_rdata_n;
    logic              win, win_legal;
    // On a tie the port that was not served last wins.
    assign win       = (p0_req && p1_req) ? ~owner : p1_req;
    assign win_bytes = win ? p1_num_bytes : p0_num_bytes;
    assign win_legal = win_bytes == 3'd1 || win_bytes == 3'd2 || win_bytes == 3'd4;
    always_comb begin
        state_n       = state;
        m_start_n     = m_start;
        m_is_write_n  = m_is_write;
        m_num_bytes_n = m_num_bytes;
        m_addr_n      = m_addr;
        m_wdata_n     = m_wdata;
        p0_rdata_n    = p0_rdata;
        p1_rdata_n    = p1_rdata;
        owner_n       = owner;
        p0_done_n     = 1'b0;
        p1_done_n     = 1'b0;
        case (state)
            IDLE: if (p0_req || p1_req) begin
                owner_n       = win;
                m_is_write_n  = win ? p1_is_write : p0_is_write;
                m_num_bytes_n = win_bytes;
                m_addr_n      = win ? p1_addr : p0_addr;
                m_wdata_n     = win ? p1_wdata : p0_wdata;
                state_n       = win_legal ? ISSUE : DONE;
                p0_done_n     = !win_legal && !win;
                p1_done_n     = !win_legal && win;
                p0_rdata_n    = (!win_legal && !win) ? 32'd0 : p0_rdata;
                p1_rdata_n    = (!win_legal && win) ? 32'd0 : p1_rdata;
            end
            ISSUE: begin
                m_start_n = 1'b1;
                state_n   = WAIT;
            end
            WAIT: if (m_done) begin
                m_start_n  = 1'b0;
                p0_done_n  = !owner;
                p1_done_n  = owner;
                p0_rdata_n = owner ? p0_rdata : m_rdata;
                p1_rdata_n = owner ? m_rdata : p1_rdata;
                state_n    = DONE;
            end
            DONE:    state_n = RELEASE;
            RELEASE: state_n = m_done ? RELEASE : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_start     <= 1'b0;
            m_is_write  <= 1'b0;
            m_num_bytes <= 3'd0;
            m_addr      <= '0;
            m_wdata     <= 32'd0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            p0_rdata    <= 32'd0;
            p1_rdata    <= 32'd0;
            owner       <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            m_start     <= m_start_n;
            m_is_write  <= m_is_write_n;
            m_num_bytes <= m_num_bytes_n;
            m_addr      <= m_addr_n;
            m_wdata     <= m_wdata_n;
            p0_done     <= p0_done_n;
            p1_done     <= p1_done_n;
            p0_rdata    <= p0_rdata_n;
            p1_rdata    <= p1_rdata_n;
            owner       <= owner_n;
            busy        <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with a simple mem_bus responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_bus_arbiter;
    localparam int ADDR_W = 18;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              p0_req = 1'b0, p0_is_write = 1'b0, p1_req = 1'b0, p1_is_write = 1'b0;
    logic [2:0]        p0_num_bytes = 3'd0, p1_num_bytes = 3'd0;
    logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
    logic [31:0]       p0_wdata = 32'd0, p1_wdata = 32'd0;
    logic              p0_done, p1_done, m_start, m_is_write, owner, busy;
    logic [31:0]       p0_rdata, p1_rdata, m_wdata;
    logic [2:0]        m_num_bytes;
    logic [ADDR_W-1:0] m_addr;
    logic              m_done = 1'b0;
    logic [31:0]       resp = 32'd0;
    int                lat = 5;
    int                cnt = 0;
    int                n_cmp = 0, n_err = 0;

    mem_bus_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_is_write(p0_is_write), .p0_num_bytes(p0_num_bytes),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_is_write(p1_is_write), .p1_num_bytes(p1_num_bytes),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .m_start(m_start), .m_is_write(m_is_write), .m_num_bytes(m_num_bytes),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_done(m_done), .m_rdata(resp),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // mem_bus responder: done rises lat cycles after start, held until start drops.
    always @(posedge clk) begin
        if (!m_start) begin
            m_done <= 1'b0;
            cnt    <= 0;
        end else if (!m_done) begin
            if (cnt == lat - 1) m_done <= 1'b1;
            cnt <= cnt + 1;
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit port, output int cyc, output bit other);
        cyc = 0;
        other = 1'b0;
        do begin
            step();
            cyc++;
            other |= port ? p0_done : p1_done;
        end while (!(port ? p1_done : p0_done) && cyc < 40);
    endtask

    int  cyc;
    bit  other, ok, port;

    initial begin
        repeat (2) step();
        chk("rst_m_start", m_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 1);
        chk("rst_done", {p0_done, p1_done}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_rdata", p0_rdata | p1_rdata, 0);
        rst_n = 1'b1;
        step();

        // single port 0 load
        resp = 32'hDEADBEEF;
        p0_req = 1'b1; p0_addr = 18'h00010; p0_num_bytes = 3'd4;
        step();
        chk("t1_issue_m_start", m_start, 0);
        chk("t1_owner", owner, 0);
        chk("t1_busy", busy, 1);
        chk("t1_m_addr", m_addr, 32'h10);
        step();
        chk("t1_m_start", m_start, 1);
        wait_done(0, cyc, other);
        chk("t1_latency", cyc, 6);
        chk("t1_p0_rdata", p0_rdata, 32'hDEADBEEF);
        chk("t1_p1_done_quiet", other, 0);
        p0_req = 1'b0;
        step();
        chk("t1_done_one_cycle", p0_done, 0);
        chk("t1_release_busy", busy, 1);
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_m_addr_held", m_addr, 32'h10);

        // tie after reset
        rst_n = 1'b0;
        step();
        chk("t2_rst_owner", owner, 1);
        chk("t2_rst_rdata", p0_rdata, 0);
        rst_n = 1'b1;
        resp = 32'h12345678;
        p0_req = 1'b1; p0_addr = 18'h00100; p0_num_bytes = 3'd2;
        p1_req = 1'b1; p1_addr = 18'h00200; p1_num_bytes = 3'd4;
        step();
        chk("t2_first_owner", owner, 0);
        chk("t2_first_addr", m_addr, 32'h100);
        wait_done(0, cyc, other);
        chk("t2_p0_done", p0_done, 1);
        chk("t2_p0_rdata", p0_rdata, 32'h12345678);
        chk("t2_p1_quiet", other, 0);
        p0_req = 1'b0;
        resp = 32'h87654321;
        wait_done(1, cyc, other);
        chk("t2_p1_done", p1_done, 1);
        chk("t2_second_owner", owner, 1);
        chk("t2_second_addr", m_addr, 32'h200);
        chk("t2_p1_rdata", p1_rdata, 32'h87654321);
        chk("t2_p0_rdata_kept", p0_rdata, 32'h12345678);
        chk("t2_p0_quiet", other, 0);
        p1_req = 1'b0;
        repeat (2) step();

        // starvation: both held for six transfers
        resp = 32'h11112222; lat = 2;
        p0_req = 1'b1; p0_addr = 18'h00300; p0_num_bytes = 3'd1;
        p1_req = 1'b1; p1_addr = 18'h00400; p1_num_bytes = 3'd1;
        for (int i = 0; i < 6; i++) begin
            cyc = 0;
            do begin
                step();
                cyc++;
                chk("t3_no_double_done", p0_done & p1_done, 0);
            end while (!(p0_done || p1_done) && cyc < 40);
            port = p1_done;
            chk($sformatf("t3_order_%0d", i), {31'd0, port}, i % 2);
            chk($sformatf("t3_addr_%0d", i), m_addr, (i % 2) ? 32'h400 : 32'h300);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) step();
        chk("t3_idle", busy, 0);

        // port 1 store pass-through
        resp = 32'h0BADF00D; lat = 3;
        p1_req = 1'b1; p1_is_write = 1'b1; p1_addr = 18'h20004;
        p1_num_bytes = 3'd2; p1_wdata = 32'h0000A5A5;
        cyc = 0;
        do begin step(); cyc++; end while (!m_start && cyc < 10);
        chk("t4_start", m_start, 1);
        ok = 1'b1;
        cyc = 0;
        while (!p1_done && cyc < 40) begin
            ok &= m_start && m_is_write && m_num_bytes == 3'd2 &&
                  m_addr == 18'h20004 && m_wdata == 32'h0000A5A5;
            step();
            cyc++;
        end
        chk("t4_fields_stable", ok, 1);
        chk("t4_wait_cycles", cyc, 4);
        chk("t4_p1_done", p1_done, 1);
        chk("t4_p1_rdata", p1_rdata, 32'h0BADF00D);
        chk("t4_p0_rdata_kept", p0_rdata, 32'h11112222);
        p1_req = 1'b0; p1_is_write = 1'b0;
        repeat (3) step();

        // illegal size
        p0_req = 1'b1; p0_addr = 18'h00050; p0_num_bytes = 3'd3;
        step();
        chk("t5_p0_done", p0_done, 1);
        chk("t5_p0_rdata", p0_rdata, 0);
        chk("t5_m_start", m_start, 0);
        chk("t5_num_bytes", m_num_bytes, 3);
        p0_req = 1'b0;
        step();
        chk("t5_done_cleared", p0_done, 0);
        chk("t5_m_start_still", m_start, 0);
        step();
        chk("t5_idle", busy, 0);

        // reset during WAIT
        resp = 32'hCAFEF00D; lat = 5;
        p0_req = 1'b1; p0_addr = 18'h00060; p0_num_bytes = 3'd4;
        cyc = 0;
        do begin step(); cyc++; end while (!m_start && cyc < 10);
        chk("t6_start", m_start, 1);
        rst_n = 1'b0;
        step();
        chk("t6_m_start_drop", m_start, 0);
        chk("t6_busy", busy, 0);
        chk("t6_owner", owner, 1);
        chk("t6_no_done", {p0_done, p1_done}, 0);
        rst_n = 1'b1;
        wait_done(0, cyc, other);
        chk("t6_latency", cyc, 8);
        chk("t6_p0_rdata", p0_rdata, 32'hCAFEF00D);
        p0_req = 1'b0;
        repeat (3) step();
        chk("t6_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-port arbiter sharing the single serial `mem_bus` between requester 0 (CPU fetch/load/store) and requester 1 (debug/program loader).
- Owns the `start_request`/`request_done` handshake toward `mem_bus`.
- Latches the winning requester's command and returns fetched data with a one-cycle done pulse.
- Round-robin priority, so neither port starves while the other is continuously requesting.

Parameters:
- ADDR_W, 18, width of memory target address (16 bits plus 2 chip-select/space bits).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- p0_req  input  1  port 0 request; held high with stable fields until p0_done
- p0_is_write  input  1  port 0 store (1) / load (0)
- p0_num_bytes  input  3  port 0 transfer size; legal values 1, 2, 4
- p0_addr  input  ADDR_W  port 0 target address
- p0_wdata  input  32  port 0 store data
- p0_done  output  1  port 0 completion pulse
- p0_rdata  output  32  port 0 read data, valid while p0_done=1
- p1_req, p1_is_write, p1_num_bytes, p1_addr, p1_wdata, p1_done, p1_rdata  same as port 0, for port 1
- m_start  output  1  `mem_bus` start_request (level)
- m_is_write  output  1  `mem_bus` is_write
- m_num_bytes  output  3  `mem_bus` num_bytes
- m_addr  output  ADDR_W  `mem_bus` target_address
- m_wdata  output  32  `mem_bus` write_value
- m_done  input  1  `mem_bus` request_done (level, high until m_start drops)
- m_rdata  input  32  `mem_bus` fetched_value
- owner  output  1  port currently or most recently granted
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset values: state=IDLE; m_start=0; m_is_write=0; m_num_bytes=0; m_addr=0; m_wdata=0; p0_done=p1_done=0; p0_rdata=p1_rdata=0; owner=1 (so port 0 wins the first tie); busy=0.
- States: IDLE, ISSUE, WAIT, DONE, RELEASE. All outputs are registered.
- IDLE:
  - Only one req high → grant that port.
  - Both high → grant the port != owner.
  - On grant: owner<=winner; latch is_write/num_bytes/addr/wdata into m_* registers.
  - If latched num_bytes is not 1, 2 or 4 → go to DONE directly with rdata=0; m_start is never raised.
  - Otherwise → ISSUE.
- ISSUE: m_start<=1; → WAIT. m_start therefore rises 2 cycles after req is first sampled in IDLE.
- WAIT: hold m_start=1 and m_* stable. When m_done=1: owner's rdata<=m_rdata, owner's done<=1, m_start<=0; → DONE.
- DONE (exactly 1 cycle): done pulse is visible. The requester must drop req on this edge. Clear done; → RELEASE.
- RELEASE: wait for m_done=0 (the `mem_bus` returns to idle), then → IDLE. Minimum 1 cycle, which guarantees the served req is low before re-arbitration.
- m_* outputs stay latched after completion; they are only updated at the next grant.
- rdata of the non-owner port is unchanged; each port's rdata holds its value until its next completion.
- A req arriving while busy is queued implicitly (req held) and arbitrated at the next IDLE.
- Request to completion, with the `mem_bus` taking N cycles from m_start to m_done: done pulses N+3 cycles after req is sampled. Back-to-back grants are ≥2 cycles apart (RELEASE→IDLE→grant).
- Only the owner's done can pulse; p0_done and p1_done are never high simultaneously.
- Reset asserted mid-transfer: all state returns to reset values on that edge, m_start drops immediately, no done pulse is produced, owner=1.
- req deasserted by a requester before its done is a protocol violation: the transfer completes anyway and done still pulses.

Test Plan:
- Single port 0 load: p0_req=1, addr=0x00010, bytes=4; model returns 0xDEADBEEF after 5 cycles → m_start high from cycle 2, p0_done one cycle with p0_rdata=0xDEADBEEF, p1_done=0 throughout.
- Tie after reset: p0_req and p1_req both high in the same cycle → port 0 served first (owner=0), then port 1 (owner=1); m_addr reflects each port's address in turn.
- Starvation check: both ports hold req continuously for 6 transfers → grant order 0,1,0,1,0,1; no port served twice consecutively.
- Store pass-through: p1 write, addr=0x20004, bytes=2, wdata=0x0000A5A5 → m_is_write=1, m_num_bytes=2, m_addr=0x20004, m_wdata=0x0000A5A5 stable for the whole WAIT phase; p1_done pulses.
- Illegal size: p0_num_bytes=3 → m_start stays 0, p0_done pulses 1 cycle later with p0_rdata=0.
- Reset during WAIT: rst_n=0 for one cycle while m_start=1 → next cycle m_start=0, busy=0, owner=1, no done pulse; a subsequent p0 request completes normally.
